// File: rtl/date_counter_pkg.sv
// Shared definitions for the calendar counter: set_mode encodings, month lengths
// and the Gregorian leap / month-length helpers.
package date_counter_pkg;

  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_DAY   = 3'd1,
    MODE_MONTH = 3'd2,
    MODE_YEAR  = 3'd3,
    MODE_WDAY  = 3'd4
  } set_mode_e;

  localparam logic [4:0] LEN_31 = 5'd31;
  localparam logic [4:0] LEN_30 = 5'd30;
  localparam logic [4:0] LEN_29 = 5'd29;
  localparam logic [4:0] LEN_28 = 5'd28;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  function automatic logic is_leap(input logic [31:0] y);
    return ((y % 32'd4) == 32'd0) &&
           (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    logic [4:0] len;
    case (m)
      4'd2:                    len = lp ? LEN_29 : LEN_28;
      4'd4, 4'd6, 4'd9, 4'd11: len = LEN_30;
      default:                 len = LEN_31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/date_counter_btn_edge.sv
// Press detector for one active-low button: reports a 1->0 transition once,
// and ignores a button that is already held low when reset is released.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic hist_q, hist_d;
  logic arm_q, arm_d;

  // Previous sample, plus an arm bit that stays clear until the button is seen released.
  always_comb begin
    hist_d = btn_n;
    arm_d  = arm_q | btn_n;
  end

  // History and arm registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b1;
      arm_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      arm_q  <= arm_d;
    end
  end

  assign press = arm_q & hist_q & ~btn_n;

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar with button-driven set modes.
// Optional weekday tracking is enabled by defining DATE_COUNTER_WEEKDAY_EN.
module date_counter
  import date_counter_pkg::*;
#(
  parameter int YEAR_W      = 13,
  parameter int YEAR_MIN    = 2000,
  parameter int YEAR_MAX    = 2199,
  parameter int WDAY_AT_MIN = 6
) (
  input  logic              clk_1Hz,
  input  logic              rst,
  input  logic              day_tick,
  input  logic [2:0]        set_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        weekday,
  output logic              leap,
  output logic              year_wrap
);

  localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_ONE = YEAR_W'(1);

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              wrap_q, wrap_d;
  logic              up_press_s, dn_press_s, up_s, dn_s;
  logic              leap_s;
  logic [4:0]        cur_len_s, new_len_s;

  btn_edge u_btn_up (.clk(clk_1Hz), .rst(rst), .btn_n(btn_up),   .press(up_press_s));
  btn_edge u_btn_dn (.clk(clk_1Hz), .rst(rst), .btn_n(btn_down), .press(dn_press_s));

  assign leap_s    = is_leap(32'(year_q));
  assign cur_len_s = month_len(month_q, leap_s);
  assign up_s      = up_press_s & ~dn_press_s;
  assign dn_s      = dn_press_s & ~up_press_s;

`ifdef DATE_COUNTER_WEEKDAY_EN
  logic [2:0] wday_q, wday_d;
`endif

  // Next-state: set-mode edits or run-mode rollover, then clamp day to the new month.
  always_comb begin
    day_d     = day_q;
    month_d   = month_q;
    year_d    = year_q;
    wrap_d    = 1'b0;
    new_len_s = cur_len_s;
`ifdef DATE_COUNTER_WEEKDAY_EN
    wday_d    = wday_q;
`endif
    case (set_mode)
      MODE_DAY: begin
        if (up_s)      day_d = (day_q >= cur_len_s) ? 5'd1 : day_q + 5'd1;
        else if (dn_s) day_d = (day_q == 5'd1) ? cur_len_s : day_q - 5'd1;
        else           day_d = day_q;
      end
      MODE_MONTH: begin
        if (up_s)      month_d = (month_q == MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
        else if (dn_s) month_d = (month_q == MONTH_JAN) ? MONTH_DEC : month_q - 4'd1;
        else           month_d = month_q;
      end
      MODE_YEAR: begin
        if (up_s) begin
          wrap_d = (year_q == Y_MAX);
          year_d = (year_q == Y_MAX) ? Y_MIN : year_q + Y_ONE;
        end else if (dn_s) begin
          wrap_d = (year_q == Y_MIN);
          year_d = (year_q == Y_MIN) ? Y_MAX : year_q - Y_ONE;
        end else begin
          year_d = year_q;
        end
      end
`ifdef DATE_COUNTER_WEEKDAY_EN
      MODE_WDAY: begin
        if (up_s)      wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
        else if (dn_s) wday_d = (wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1;
        else           wday_d = wday_q;
      end
`endif
      default: begin
        if (day_tick) begin
`ifdef DATE_COUNTER_WEEKDAY_EN
          wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
`endif
          if (day_q >= cur_len_s) begin
            day_d = 5'd1;
            if (month_q == MONTH_DEC) begin
              month_d = MONTH_JAN;
              wrap_d  = (year_q == Y_MAX);
              year_d  = (year_q == Y_MAX) ? Y_MIN : year_q + Y_ONE;
            end else begin
              month_d = month_q + 4'd1;
            end
          end else begin
            day_d = day_q + 5'd1;
          end
        end else begin
          day_d = day_q;
        end
      end
    endcase
    // Month or year edits can shorten the month under the current day.
    new_len_s = month_len(month_d, is_leap(32'(year_d)));
    if (day_d > new_len_s) day_d = new_len_s;
    else                   day_d = day_d;
  end

  // Calendar state registers.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      day_q   <= 5'd1;
      month_q <= MONTH_JAN;
      year_q  <= Y_MIN;
      wrap_q  <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DATE_COUNTER_WEEKDAY_EN
  // Weekday register.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) wday_q <= 3'(WDAY_AT_MIN);
    else     wday_q <= wday_d;
  end
  assign weekday = wday_q;
`else
  assign weekday = 3'd0;
`endif

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign leap      = leap_s;
  assign year_wrap = wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: directed calendar scenarios plus a
// randomized run against a date model built from calendar arithmetic.
module tb_date_counter;

  localparam int YMIN = 2000;
  localparam int YMAX = 2199;
`ifdef DATE_COUNTER_WEEKDAY_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        clk_1Hz = 1'b0;
  logic        rst = 1'b1;
  logic        day_tick = 1'b0;
  logic [2:0]  set_mode = 3'd0;
  logic        btn_up = 1'b1;
  logic        btn_down = 1'b1;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [12:0] year;
  logic [2:0]  weekday;
  logic        leap;
  logic        year_wrap;

  int checks = 0;
  int errors = 0;

  int m_day, m_mon, m_year, m_wday;
  bit m_wrap, m_pu, m_pd;
  int base_len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  date_counter dut (
    .clk_1Hz(clk_1Hz), .rst(rst), .day_tick(day_tick), .set_mode(set_mode),
    .btn_up(btn_up), .btn_down(btn_down), .day(day), .month(month), .year(year),
    .weekday(weekday), .leap(leap), .year_wrap(year_wrap)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic bit leap_f(int y);
    return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int y);
    return base_len[m-1] + ((m == 2 && leap_f(y)) ? 1 : 0);
  endfunction

  function automatic logic [26:0] pack(int d, int m, int y, int w, bit l, bit wr);
    return {5'(d), 4'(m), 13'(y), 3'(w), l, wr};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {day, month, year, weekday, leap, year_wrap};
  endfunction

  function automatic logic [26:0] mdl_vec();
    return pack(m_day, m_mon, m_year, m_wday, leap_f(m_year), m_wrap);
  endfunction

  task automatic model_reset();
    m_day = 1; m_mon = 1; m_year = YMIN; m_wday = WEN ? 6 : 0;
    m_wrap = 1'b0; m_pu = 1'b0; m_pd = 1'b0;
  endtask

  // One clock: predict the next date from the current inputs, then advance.
  task automatic cycle();
    int nd, nm, ny, nw, mode;
    bit nwrap, u, d, pu, pd;
    nd = m_day; nm = m_mon; ny = m_year; nw = m_wday; nwrap = 1'b0;
    pu = m_pu && !btn_up;
    pd = m_pd && !btn_down;
    u = pu && !pd;
    d = pd && !pu;
    mode = int'(set_mode);
    if (mode > 4 || (mode == 4 && !WEN)) mode = 0;
    if (mode == 0 && day_tick) begin
      nd++;
      if (nd > dim(nm, ny)) begin
        nd = 1; nm++;
        if (nm > 12) begin
          nm = 1; ny++;
          if (ny > YMAX) begin ny = YMIN; nwrap = 1'b1; end
        end
      end
      if (WEN) nw = (nw + 1) % 7;
    end else if (mode == 1) begin
      if (u) nd = nd % dim(nm, ny) + 1;
      else if (d) nd = (nd == 1) ? dim(nm, ny) : nd - 1;
    end else if (mode == 2) begin
      if (u) nm = nm % 12 + 1;
      else if (d) nm = (nm == 1) ? 12 : nm - 1;
    end else if (mode == 3) begin
      if (u) begin
        if (ny == YMAX) begin ny = YMIN; nwrap = 1'b1; end else ny++;
      end else if (d) begin
        if (ny == YMIN) begin ny = YMAX; nwrap = 1'b1; end else ny--;
      end
    end else if (mode == 4) begin
      if (u) nw = (nw + 1) % 7;
      else if (d) nw = (nw + 6) % 7;
    end
    if (nd > dim(nm, ny)) nd = dim(nm, ny);
    pu = btn_up; pd = btn_down;
    @(posedge clk_1Hz); #1;
    if (rst) model_reset();
    else begin
      m_day = nd; m_mon = nm; m_year = ny; m_wday = nw; m_wrap = nwrap;
      m_pu = pu; m_pd = pd;
    end
  endtask

  task automatic press_up();
    btn_up = 1'b0; cycle(); btn_up = 1'b1; cycle();
  endtask

  task automatic press_down();
    btn_down = 1'b0; cycle(); btn_down = 1'b1; cycle();
  endtask

  // Navigate to a date through the set modes.
  task automatic goto(int d, int m, int y);
    day_tick = 1'b0;
    set_mode = 3'd3;
    while (m_year != y) begin
      if (((y - m_year + 200) % 200) <= 100) press_up(); else press_down();
    end
    set_mode = 3'd2;
    while (m_mon != m) press_up();
    set_mode = 3'd1;
    while (m_day != d) press_up();
    set_mode = 3'd0;
    checks++;
    if (dut_vec() !== pack(d, m, y, m_wday, leap_f(y), m_wrap)) begin
      errors++;
      $display("FAIL goto: got %h expected %h", dut_vec(), pack(d, m, y, m_wday, leap_f(y), m_wrap));
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1; #1;
    model_reset();
    checks++;
    if (dut_vec() !== pack(1, 1, 2000, WEN ? 6 : 0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL reset: got %h expected %h", dut_vec(), pack(1, 1, 2000, WEN ? 6 : 0, 1'b1, 1'b0));
    end
    cycle(); cycle();
    checks++;
    if (dut_vec() !== pack(1, 1, 2000, WEN ? 6 : 0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec(), pack(1, 1, 2000, WEN ? 6 : 0, 1'b1, 1'b0));
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_leap_rollover();
    goto(28, 2, 2000);
    day_tick = 1'b1; cycle(); day_tick = 1'b0;
    checks++;
    if ({day, month, year, leap} !== {5'd29, 4'd2, 13'd2000, 1'b1}) begin
      errors++; $display("FAIL leap2000: got %0d/%0d/%0d expected 29/2/2000", day, month, year);
    end
    goto(28, 2, 2100);
    day_tick = 1'b1; cycle(); day_tick = 1'b0;
    checks++;
    if ({day, month, year, leap} !== {5'd1, 4'd3, 13'd2100, 1'b0}) begin
      errors++; $display("FAIL noleap2100: got %0d/%0d/%0d expected 1/3/2100", day, month, year);
    end
  endtask

  task automatic test_year_wrap();
    goto(31, 12, 2199);
    day_tick = 1'b1; cycle(); day_tick = 1'b0;
    checks++;
    if ({day, month, year, year_wrap} !== {5'd1, 4'd1, 13'd2000, 1'b1}) begin
      errors++; $display("FAIL wrap: got %0d/%0d/%0d wrap %0b expected 1/1/2000 wrap 1", day, month, year, year_wrap);
    end
    cycle();
    checks++;
    if (year_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse: got %0b expected 0", year_wrap);
    end
  endtask

  task automatic test_clamp();
    goto(31, 1, 2001);
    set_mode = 3'd2; press_up();
    checks++;
    if ({day, month, year} !== {5'd28, 4'd2, 13'd2001}) begin
      errors++; $display("FAIL clamp_month: got %0d/%0d/%0d expected 28/2/2001", day, month, year);
    end
    goto(29, 2, 2004);
    set_mode = 3'd3; press_up();
    checks++;
    if ({day, month, year} !== {5'd28, 4'd2, 13'd2005}) begin
      errors++; $display("FAIL clamp_year: got %0d/%0d/%0d expected 28/2/2005", day, month, year);
    end
    set_mode = 3'd0;
  endtask

  task automatic test_hold_and_both();
    goto(10, 5, 2010);
    set_mode = 3'd1;
    btn_up = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    btn_up = 1'b1; cycle();
    checks++;
    if (day !== 5'd11) begin
      errors++; $display("FAIL hold_once: got day %0d expected 11", day);
    end
    btn_up = 1'b0; btn_down = 1'b0; cycle();
    btn_up = 1'b1; btn_down = 1'b1; cycle();
    checks++;
    if ({day, month, year} !== {5'd11, 4'd5, 13'd2010}) begin
      errors++; $display("FAIL both_btn: got %0d/%0d/%0d expected 11/5/2010", day, month, year);
    end
    set_mode = 3'd0;
  endtask

  task automatic test_reset_midpress();
    goto(15, 6, 2020);
    set_mode = 3'd1; btn_up = 1'b0; cycle();
    #2 rst = 1'b1; #1;
    model_reset();
    checks++;
    if ({day, month, year, year_wrap} !== {5'd1, 4'd1, 13'd2000, 1'b0}) begin
      errors++; $display("FAIL async_rst: got %0d/%0d/%0d expected 1/1/2000", day, month, year);
    end
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (day !== 5'd1) begin
      errors++; $display("FAIL held_through_rst: got day %0d expected 1", day);
    end
    btn_up = 1'b1; cycle();
    btn_up = 1'b0; cycle(); btn_up = 1'b1; cycle();
    checks++;
    if (day !== 5'd2) begin
      errors++; $display("FAIL press_after_rst: got day %0d expected 2", day);
    end
    set_mode = 3'd0;
  endtask

  task automatic test_weekday();
    rst = 1'b1; #1; model_reset(); cycle(); rst = 1'b0; cycle();
    day_tick = 1'b1; cycle(); day_tick = 1'b0;
    checks++;
    if ({day, weekday} !== {5'd2, 3'd0}) begin
      errors++; $display("FAIL wday_tick: got day %0d wd %0d expected day 2 wd 0", day, weekday);
    end
    set_mode = 3'd1; day_tick = 1'b1; cycle();
    checks++;
    if ({day, month, year, weekday} !== {5'd2, 4'd1, 13'd2000, 3'd0}) begin
      errors++; $display("FAIL set_ignores_tick: got %0d/%0d/%0d wd %0d expected 2/1/2000 wd 0", day, month, year, weekday);
    end
    set_mode = 3'd4; cycle(); day_tick = 1'b0;
    checks++;
    if (day !== (WEN ? 5'd2 : 5'd3)) begin
      errors++; $display("FAIL mode4_tick: got day %0d expected %0d", day, WEN ? 2 : 3);
    end
    press_down();
    checks++;
    if (weekday !== (WEN ? 3'd6 : 3'd0)) begin
      errors++; $display("FAIL wday_down: got %0d expected %0d", weekday, WEN ? 6 : 0);
    end
    set_mode = 3'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      set_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) set_mode = 3'd0;
      day_tick = ($urandom_range(0, 2) == 0);
      btn_up   = ($urandom_range(0, 2) != 0);
      btn_down = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    day_tick = 1'b0; btn_up = 1'b1; btn_down = 1'b1; set_mode = 3'd0;
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_leap_rollover();
    test_year_wrap();
    test_clamp();
    test_hold_and_both();
    test_reset_midpress();
    test_weekday();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/date_counter.md
DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 Parameter YEAR_W, default 13, sets the year output width in bits.
REQ-002 Parameter YEAR_MIN, default 2000, sets the lowest legal year and the reset year.
REQ-003 Parameter YEAR_MAX, default 2199, sets the highest legal year.
REQ-004 Parameter WDAY_AT_MIN, default 6, sets the weekday of 01/01/YEAR_MIN (0=Sunday … 6=Saturday).
REQ-005 clk_1Hz  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 day_tick  in  1  one-cycle pulse from the time-of-day counter at the 23:59:59→00:00:00 rollover.
REQ-008 set_mode  in  3  0 = run, 1 = set day, 2 = set month, 3 = set year, 4 = set weekday; other values behave as run.
REQ-009 btn_up  in  1  increment button, active-low.
REQ-010 btn_down  in  1  decrement button, active-low.
REQ-011 day  out  5  day of month, 1..31.
REQ-012 month  out  4  month, 1..12.
REQ-013 year  out  YEAR_W  year, YEAR_MIN..YEAR_MAX.
REQ-014 weekday  out  3  weekday, 0..6.
REQ-015 leap  out  1  high while the current year is a leap year (combinational from year).
REQ-016 year_wrap  out  1  one-cycle pulse when the year wraps in either direction.

Function
REQ-017 The block SHALL compute leap years by the full Gregorian rule: divisible by 4 and (not by 100, or by 400); 2000 is leap, 2100 is not.
REQ-018 The block SHALL compute month length as 31/30/28/29 from month and leap.
REQ-019 In run mode, on day_tick, day SHALL advance by 1; past month length, day→1 and month advances; past 12, month→1 and year advances; past YEAR_MAX, year→YEAR_MIN with year_wrap=1 for one cycle.
REQ-020 In any set mode, day_tick SHALL be ignored.
REQ-021 The block SHALL register each button and act only on a press event (previous sample 1, current sample 0), once per press.
REQ-022 A press event on both buttons in the same cycle SHALL cause no change.
REQ-023 Set day: up wraps month-length→1; down wraps 1→month-length.
REQ-024 Set month: up wraps 12→1; down wraps 1→12; year unchanged.
REQ-025 Set year: up wraps YEAR_MAX→YEAR_MIN; down wraps YEAR_MIN→YEAR_MAX; year_wrap pulses on either wrap.
REQ-026 After any month or year change, day SHALL be clamped in the same update to the new month length if it exceeds it.
REQ-027 Set-mode edits SHALL not change weekday; weekday is changed only in set weekday mode (up 6→0, down 0→6).
REQ-028 All outputs SHALL be registered, except leap, and SHALL update one cycle after the triggering edge.

Reset
REQ-029 While rst=1, the outputs SHALL be day=1, month=1, year=YEAR_MIN, weekday=WDAY_AT_MIN, year_wrap=0, and both button history registers SHALL be 1.
REQ-030 Assertion of rst mid-operation or mid-press SHALL take effect immediately; a button held low through deassertion SHALL not register a press.

Configuration
REQ-031 With DATE_COUNTER_WEEKDAY_EN defined, the weekday register, its day_tick advance (6→0), and set_mode 4 SHALL be present.
REQ-032 Without DATE_COUNTER_WEEKDAY_EN, weekday SHALL be tied to 0 and set_mode 4 SHALL behave as run.

Structure
REQ-033 The shared package SHALL hold the set_mode encodings, the month-length constants and the leap/month-length function.
REQ-034 The button press detector SHALL be one sub-module, btn_edge, instantiated once per button.

Verification
REQ-035 Reset pulse -> 01/01/2000, weekday 6, leap 1, year_wrap 0.
REQ-036 28/02/2000 tick -> 29/02/2000; 28/02/2100 tick -> 01/03/2100.
REQ-037 31/12/2199 tick -> 01/01/2000, with year_wrap high for exactly one cycle.
REQ-038 31/01/2001, set month, up press -> 28/02/2001; set year from 29/02/2004, up -> 28/02/2005.
REQ-039 Set day, btn_up held low for 5 cycles -> exactly one increment; both buttons pressed together -> no change.
REQ-040 With the macro defined: weekday 6, tick -> 0; set mode with a tick -> date unchanged.
